// File: rtl/mips_muldiv_unit_if.sv
// Start/busy/done handshake and result bus between the EX stage and mips_muldiv_unit.
// The master (pipeline) drives the request; the slave (unit) drives status and results.
interface mips_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, lo, hi, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, lo, hi, div_by_zero
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider producing HI/LO for the MIPS32 EX stage.
// Optional MULDIV_EARLY_EXIT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic               clk1,
    input logic               rst,
    mips_muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e             state_q;
    logic               div_q;
    logic               sa_q;
    logic               sb_q;
    logic               dz_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   opa_q;   // |a|: multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   opb_q;   // |b|: multiplier (shifts right), or divisor
    logic [2*WIDTH-1:0] acc_q;   // product accumulator, then final {hi, lo}
    logic [WIDTH:0]     rem_q;

    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               early_exit;
    logic               run_last;
    logic [2*WIDTH-1:0] prod_aligned;
    logic               start_dz;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
        div_shift = {rem_q, opa_q[WIDTH-1]};
        div_diff  = div_shift - {2'b00, opb_q};
        start_dz  = bus.op[1] && (bus.b == '0);
`ifdef MULDIV_EARLY_EXIT_EN
        early_exit   = ~div_q && (opb_q[WIDTH-1:1] == '0);
        // Each skipped iteration is one missing right shift of the accumulator.
        prod_aligned = acc_q >> (CNT_W'(WIDTH) - cnt_q);
`else
        early_exit   = 1'b0;
        prod_aligned = acc_q;
`endif
        run_last = (cnt_q == CNT_W'(WIDTH - 1)) || early_exit;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        div_q   <= bus.op[1];
                        sa_q    <= bus.op[0] & bus.a[WIDTH-1];
                        sb_q    <= bus.op[0] & bus.b[WIDTH-1];
                        opa_q   <= (bus.op[0] & bus.a[WIDTH-1]) ? -bus.a : bus.a;
                        opb_q   <= (bus.op[0] & bus.b[WIDTH-1]) ? -bus.b : bus.b;
                        dz_q    <= start_dz;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        rem_q   <= '0;
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        state_q <= start_dz ? StFix : StRun;
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (div_q) begin
                        opa_q <= {opa_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
                        rem_q <= div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
                    end else begin
                        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                        opb_q <= opb_q >> 1;
                    end
                    if (run_last) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (div_q && dz_q) begin
                        // Negating |a| recovers the original dividend bits.
                        acc_q <= {(sa_q ? -opa_q : opa_q), {WIDTH{1'b1}}};
                    end else if (div_q) begin
                        acc_q <= {(sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0]),
                                  ((sa_q ^ sb_q) ? -opa_q : opa_q)};
                    end else begin
                        acc_q <= (sa_q ^ sb_q) ? -prod_aligned : prod_aligned;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    lo_q    <= acc_q[WIDTH-1:0];
                    hi_q    <= acc_q[2*WIDTH-1:WIDTH];
                    dbz_q   <= dz_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.lo          = lo_q;
    assign bus.hi          = hi_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: vector table driven through a scoreboard queue,
// plus hand-written reset and abort sequences.
module tb_mips_muldiv_unit;

    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } vec_t;

    logic clk1;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] prev_lo;

    vec_t vecs[15];
    vec_t sb[$];

    mips_muldiv_unit_if #(.WIDTH(WIDTH)) bus_if ();

    mips_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus_if)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Cycles from the accepting edge to the edge that raises done.
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        int r;
        logic [31:0] mag;
        if (op[1]) return (b == 32'd0) ? 2 : 34;
        mag = (op[0] && b[31]) ? -b : b;
        r = 34;
`ifdef MULDIV_EARLY_EXIT_EN
        r = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) r = i + 1;
        r = r + 2;
`else
        if (mag == 32'd0) r = 34;
`endif
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input bit inject);
        vec_t e;
        int   n;
        bit   seen;
        @(negedge clk1);
        bus_if.start = 1'b1;
        bus_if.op    = v.op;
        bus_if.a     = v.a;
        bus_if.b     = v.b;
        sb.push_back(v);
        @(negedge clk1);
        bus_if.start = 1'b0;
        chk("busy_after_accept", bus_if.busy, 1);
        chk("dbz_cleared_on_start", bus_if.div_by_zero, 0);
        chk("lo_holds_previous", bus_if.lo, prev_lo);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            if (bus_if.done) begin
                seen = 1'b1;
            end else begin
                if (inject && n == 10) begin
                    bus_if.start = 1'b1;
                    bus_if.op    = 2'b11;
                    bus_if.a     = 32'h55;
                    bus_if.b     = 32'h0;
                end else begin
                    bus_if.start = 1'b0;
                end
                @(negedge clk1);
                n++;
            end
        end
        bus_if.start = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("lo", bus_if.lo, e.lo);
            chk("hi", bus_if.hi, e.hi);
            chk("div_by_zero", bus_if.div_by_zero, e.dbz);
            chk("busy_low_with_done", bus_if.busy, 0);
            chk("latency", n, exp_lat(e.op, e.b));
            prev_lo = e.lo;
            @(negedge clk1);
            chk("done_one_cycle", bus_if.done, 0);
        end
    endtask

    initial begin
        int done_cnt;
        vec_t v;
        checks   = 0;
        failures = 0;
        prev_lo  = 32'd0;
        rst      = 1'b0;
        bus_if.start = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.a     = '0;
        bus_if.b     = '0;

        vecs[0]  = '{2'b00, 32'd7,        32'd720,      32'd5040,     32'd0,        1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
        vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{2'b10, 32'd200,      32'd7,        32'd28,       32'd4,        1'b0};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
        vecs[6]  = '{2'b10, 32'h1234,     32'd0,        32'hFFFFFFFF, 32'h1234,     1'b1};
        vecs[7]  = '{2'b00, 32'd2,        32'd3,        32'd6,        32'd0,        1'b0};
        vecs[8]  = '{2'b00, 32'hFFFF,     32'd3,        32'h2FFFD,    32'd0,        1'b0};
        vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        vecs[10] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[11] = '{2'b11, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1};
        vecs[12] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0};
        vecs[13] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[14] = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};

        // Asynchronous reset between edges, then hold for three clocks after release.
        #2 rst = 1'b1;
        #1;
        chk("rst_async_lohi", {bus_if.lo, bus_if.hi}, 0);
        chk("rst_async_flags", {bus_if.busy, bus_if.done, bus_if.div_by_zero}, 0);
        repeat (2) @(negedge clk1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            chk("rst_hold_lohi", {bus_if.lo, bus_if.hi}, 0);
            chk("rst_hold_flags", {bus_if.busy, bus_if.done, bus_if.div_by_zero}, 0);
        end

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i == 0);
        end

        // Abort a multiply mid-flight with reset; no done may follow.
        @(negedge clk1);
        bus_if.start = 1'b1;
        bus_if.op    = 2'b00;
        bus_if.a     = 32'd100;
        bus_if.b     = 32'd100;
        @(negedge clk1);
        bus_if.start = 1'b0;
        repeat (10) @(negedge clk1);
        #3 rst = 1'b1;
        #1;
        chk("abort_rst_lohi", {bus_if.lo, bus_if.hi}, 0);
        chk("abort_rst_flags", {bus_if.busy, bus_if.done, bus_if.div_by_zero}, 0);
        @(negedge clk1);
        rst = 1'b0;
        prev_lo = 32'd0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk1);
            if (bus_if.done) done_cnt++;
        end
        chk("no_done_after_abort", done_cnt, 0);
        chk("busy_idle_after_abort", bus_if.busy, 0);

        v = '{2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0};
        run_vec(v, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the MIPS32 pipeline EX stage. It generalises the single-cycle MUL into a WIDTH-bit shift-add multiplier and restoring divider. It supports signed and unsigned operations and produces HI/LO results through a start/busy/done handshake. The pipeline stalls on busy and writes lo/hi back on done.

Parameters:
WIDTH, 32, operand width; lo and hi are each WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk1  input  1  single system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high from the accepting edge until the done edge
done  output  1  one-cycle pulse; lo/hi/div_by_zero valid from this cycle
lo  output  WIDTH  product low half / quotient
hi  output  WIDTH  product high half / remainder
div_by_zero  output  1  set with done when a divide had b==0; cleared at next accepted start

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, lo=0, hi=0, div_by_zero=0; counter and internal registers cleared.
- Reset mid-operation: the operation is aborted, no done is produced, and all outputs are reset values.
- States:
  - IDLE: start=1 at edge E0 latches op, |a|, |b|, sign flags (signed ops only), busy=1, counter=0.
    - Divide with b==0 goes to FIX.
    - Otherwise goes to RUN.
  - RUN: one bit per cycle.
    - MUL: if multiplier LSB=1, add multiplicand to upper accumulator; shift the 2*WIDTH accumulator right 1.
    - DIV: shift remainder:quotient left 1; trial-subtract divisor; on non-negative result keep the difference and set quotient LSB.
    - Counter increments each cycle; after WIDTH cycles go to FIX.
  - FIX: one cycle.
    - MUL signed with sa^sb: negate the 2*WIDTH product.
    - DIV signed: negate quotient if sa^sb; negate remainder if sa.
    - Then go to DONE.
  - DONE: lo/hi registered, done=1, busy=0, return to IDLE. start is not accepted in this cycle.
- Latency: done high in the cycle after edge E0+WIDTH+2. Divide by zero: after edge E0+2.
- Divide by zero result: lo=all ones, hi=a (original value), div_by_zero=1.
- DIV min/-1: quotient wraps to min (0x80000000 at WIDTH=32), remainder 0; no flag.
- start while busy=1 or in DONE: ignored, with no effect on the operation in flight.
- lo/hi hold the previous result until the next done.
- Arithmetic width rules:
  - Magnitudes are WIDTH-bit unsigned; |min| is represented as 2^(WIDTH-1).
  - Divider remainder register is WIDTH+1 bits.
  - All negation is two's complement modulo 2^(2*WIDTH) or 2^WIDTH.

Optional Feature:
MULDIV_EARLY_EXIT_EN
- Defined: MUL/MULU leaves RUN when the remaining multiplier bits are all zero.
  - RUN cycles = max(1, msb_index(|b|)+1).
  - The accumulator is shifted right by the skipped count in FIX, so results are unchanged.
  - Done follows edge E0+RUN+2.
- Undefined: fixed WIDTH RUN cycles for all operations. Divide is unaffected either way.

Test Plan:
1. Reset: rst pulse asynchronously between edges -> busy=0, done=0, lo=0, hi=0, div_by_zero=0 immediately; reset values hold for 3 clocks after release with start=0.
2. MULU a=7, b=720 (WIDTH=32, macro off) -> done after edge E0+34, lo=5040, hi=0, busy low with done; second start pulsed at cycle 10 ignored.
3. MUL a=-3 (0xFFFFFFFD), b=5 -> lo=0xFFFFFFF1, hi=0xFFFFFFFF; MUL 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
4. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=200, b=7 -> lo=28, hi=4; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
5. DIVU a=0x1234, b=0 -> done after edge E0+2, lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; next MULU 2*3 start clears the flag, lo=6.
6. rst asserted at cycle 10 of a MULU -> no done ever; next MULU 6*7 -> lo=42. With MULDIV_EARLY_EXIT_EN: MULU 0xFFFF*3 -> done after edge E0+4, lo=0x2FFFD.
